// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// ratio and a counter-width helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Bits needed to hold 0..value-1; never returns less than 1.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Divide-by-DIV strobe generator; clr holds the phase at zero so the first
// tick lands DIV cycles after clr is released.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic CLK50M,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW   = clog2_min1(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK50M) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised input, false-start rejection,
// three-sample mid-bit majority vote, stop-bit check and break recovery.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              CLK50M,
    input  logic              RST,
    input  logic              RX,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned OS_W  = clog2_min1(OVERSAMPLE);
    localparam int unsigned IDX_W = clog2_min1(BYTE_W);
    localparam int unsigned MID   = OVERSAMPLE / 2;

    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SMP_A    = OS_W'(MID - 1);
    localparam logic [OS_W-1:0]  SMP_B    = OS_W'(MID);
    localparam logic [OS_W-1:0]  SMP_C    = OS_W'(MID + 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(BYTE_W - 1);

    rx_state_t         state;
    rx_state_t         next_state;
    logic              rx_m;
    logic              rx_s;
    logic              tick;
    logic [OS_W-1:0]   os_cnt;
    logic [OS_W-1:0]   hi_cnt;
    logic              smp_a;
    logic              smp_b;
    logic [IDX_W-1:0]  bit_idx;
    logic [BYTE_W-1:0] shift_reg;
    logic              bit_end;
    logic              decide;
    logic              bit_val;
    logic              break_done;
    logic              shift_en;
    logic              load_byte;
    logic              flag_err;

    // Two-flop synchroniser, idle-high so reset never looks like a start edge.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLK50M (CLK50M),
        .RST    (RST),
        .clr    (state == IDLE),
        .tick   (tick)
    );

    assign bit_end    = tick && (os_cnt == OS_LAST);
    assign decide     = tick && (os_cnt == SMP_C);
    assign bit_val    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign break_done = tick && rx_s && (hi_cnt == OS_LAST);

    // Bit timing, mid-bit samples, data shifter and break high-time counter.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            os_cnt    <= '0;
            hi_cnt    <= '0;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end

            if (tick && (os_cnt == SMP_A)) begin
                smp_a <= rx_s;
            end
            if (tick && (os_cnt == SMP_B)) begin
                smp_b <= rx_s;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (shift_en) begin
                shift_reg <= {bit_val, shift_reg[BYTE_W-1:1]};
            end

            // Any low sample restarts the one-bit high-time requirement.
            if ((state != BREAK) || !rx_s) begin
                hi_cnt <= '0;
            end else if (tick && (hi_cnt != OS_LAST)) begin
                hi_cnt <= hi_cnt + OS_W'(1);
            end
        end
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    next_state = START;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    next_state = IDLE;
                end else if (bit_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == LAST_BIT)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    next_state = bit_val ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (break_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        load_byte = 1'b0;
        flag_err  = 1'b0;
        case (state)
            DATA: shift_en = decide;
            STOP: begin
                load_byte = decide && bit_val;
                flag_err  = decide && !bit_val;
            end
            default: ;
        endcase
    end

    // Registered outputs; rx_busy follows next_state so it matches state exactly.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_valid     <= load_byte;
            rx_frame_err <= flag_err;
            rx_busy      <= (next_state != IDLE);
            if (load_byte) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at 32 clocks per bit (DIV=2, OVERSAMPLE=16).
module tb_uart_rx_os;

    localparam int BIT_CYC = 32;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_err    = 0;
    int   t_start  = 0;
    int   t_valid  = 0;
    logic prev_evt = 1'b0;

    uart_rx_os #(
        .CLK_FREQ   (3200000),
        .BAUD       (100000),
        .OVERSAMPLE (16)
    ) dut (
        .CLK50M       (clk),
        .RST          (rst),
        .RX           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic err, input logic [7:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Output monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err) begin
            check("strobe_excl", 32'({rx_valid & rx_frame_err, prev_evt}), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({rx_valid, rx_frame_err}), 32'd0);
            end else begin
                check("strobe_kind", 32'(rx_frame_err), 32'(exp_q[0].err));
                check("strobe_data", 32'(rx_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            if (rx_valid) begin
                n_valid <= n_valid + 1;
                t_valid <= cyc;
            end
            if (rx_frame_err) begin
                n_err <= n_err + 1;
            end
        end
        prev_evt <= rx_valid | rx_frame_err;
    end

    // One frame; glitch_bit inverts one cycle at mid-bit, rst_bit pulses reset for 2 cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int glitch_bit, input int rst_bit);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) t_start = cyc;
                rx = (b == glitch_bit && c == 18) ? ~bits[b] : bits[b];
                if (b == rst_bit && c == 16) rst = 1'b1;
                if (b == rst_bit && c == 17) begin
                    check("rst_data", 32'(rx_data), 32'h00);
                    check("rst_valid", 32'(rx_valid), 32'd0);
                    check("rst_err", 32'(rx_frame_err), 32'd0);
                    check("rst_busy", 32'(rx_busy), 32'd0);
                end
                if (b == rst_bit && c == 18) rst = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_err", 32'(rx_frame_err), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        idle(10);

        // Plain frame and its latency from the start edge.
        push_exp(1'b0, 8'h61);
        send_frame(8'h61, 1'b1, -1, -1);
        wait_drain(200, "drain_61");
        check("lat_61_window", 32'((t_valid - t_start) >= 300 && (t_valid - t_start) <= 320), 32'd1);
        check("count_61", 32'({n_valid[15:0], n_err[15:0]}), 32'h0001_0000);
        idle(40);

        // Eight-cycle low pulse is a false start.
        rx = 1'b0;
        repeat (6) @(negedge clk);
        check("false_busy_hi", 32'(rx_busy), 32'd1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        k = 0;
        while (rx_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("false_busy_lo", 32'(rx_busy), 32'd0);
        idle(400);
        check("false_no_strobe", 32'({n_valid[15:0], n_err[15:0]}), 32'h0001_0000);

        // Bad stop bit, line held low, then recovery.
        push_exp(1'b1, 8'h61);
        send_frame(8'h55, 1'b0, -1, -1);
        repeat (100) @(negedge clk);
        check("break_busy", 32'(rx_busy), 32'd1);
        check("break_data_kept", 32'(rx_data), 32'h61);
        check("break_err_cnt", 32'(n_err), 32'd1);
        idle(32);
        push_exp(1'b0, 8'hA3);
        send_frame(8'hA3, 1'b1, -1, -1);
        wait_drain(200, "drain_a3");
        idle(40);

        // Back-to-back frames with no idle gap.
        push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        wait_drain(200, "drain_b2b");
        check("b2b_count", 32'({n_valid[15:0], n_err[15:0]}), 32'h0004_0001);
        idle(40);

        // Single-cycle glitch at mid-bit of data bit 3.
        push_exp(1'b0, 8'h0F);
        send_frame(8'h0F, 1'b1, 4, -1);
        wait_drain(200, "drain_glitch");
        idle(40);

        // Reset during data bit 4: nothing may appear while that frame's bits are on the line.
        send_frame(8'h3C, 1'b1, -1, 5);
        check("abort_no_strobe", 32'({n_valid[15:0], n_err[15:0]}), 32'h0005_0001);
        // Data bits 6,7 (low) form a new falling edge after reset; that frame reads 0xFE.
        push_exp(1'b0, 8'hFE);
        rx = 1'b1;
        wait_drain(400, "drain_after_abort");
        idle(64);
        push_exp(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1, -1, -1);
        wait_drain(200, "drain_3c");
        idle(10);
        check("final_data", 32'(rx_data), 32'h3C);
        check("final_count", 32'({n_valid[15:0], n_err[15:0]}), 32'h0007_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver on the CLK50M domain.
- Converts the asynchronous RX line into framed bytes, each with a one-cycle valid strobe.
- Sits directly upstream of the byte echo/transmit stage and replaces its naive one-sample-per-bit capture.
- Adds input synchronisation, false-start rejection, mid-bit majority voting and stop-bit checking.

Parameters:
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- OVERSAMPLE, 16: ticks per bit; must be ≥8 and even.
- DIV, derived: CLK_FREQ/(BAUD*OVERSAMPLE), integer division; must be ≥1.

Ports:
- CLK50M  in  1  system clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last correctly framed byte; held until the next good byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- RX synchroniser:
  - Two flops; both reset to 1.
  - All logic uses the second stage, rx_s.
- Tick generator:
  - Counter from 0 to DIV-1; tick is high for one cycle at DIV-1.
  - Counter is forced to 0 while in IDLE, so bit timing aligns to the detected falling edge.
- Oversample counter os_cnt:
  - Range 0 to OVERSAMPLE-1; advances on tick.
  - Wraps to 0 after OVERSAMPLE-1 and marks a bit boundary.
- Bit sample:
  - Majority of rx_s captured at os_cnt = M-1, M, M+1, where M = OVERSAMPLE/2.
  - Decision is taken on the tick at os_cnt = M+1.
- States and transitions:
  - IDLE: rx_s = 0 → START; os_cnt and tick counter set to 0.
  - START: decision = 1 → IDLE (false start, no outputs). Decision = 0 → DATA on the bit boundary, bit_idx = 0.
  - DATA: each decision shifts into shift_reg LSB-first. After bit_idx = 7, go to STOP at the bit boundary.
  - STOP, decision = 1: rx_data ← shift_reg, rx_valid = 1 for the next cycle, → IDLE immediately at the mid-stop decision. The remaining half-bit is the margin for back-to-back frames.
  - STOP, decision = 0: rx_frame_err = 1 for one cycle, rx_data unchanged, → BREAK.
  - BREAK: stay until rx_s = 1 for one full bit time (OVERSAMPLE ticks continuously high), then → IDLE. Any low restarts the count.
- Latency: rx_valid asserts 1 cycle after the stop-bit decision tick. From the RX falling edge that is ≈9.5 bit times plus 3 cycles (2 synchroniser + 1 register).
- Reset values:
  - rx_data = 0x00; rx_valid = 0; rx_frame_err = 0; rx_busy = 0.
  - State IDLE; all counters 0; shift_reg 0.
- Reset mid-frame aborts the frame with no strobe. The next frame requires a fresh falling edge after reset release.
- rx_valid and rx_frame_err are mutually exclusive and never high on consecutive cycles for the same frame.
- No backpressure: the downstream stage must capture rx_data on rx_valid. rx_data is stable for ≥9.5 bit times after rx_valid.

Decomposition:
- Package uart_pkg holds:
  - State encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3, BREAK=3'd4.
  - OVERSAMPLE default.
  - A clog2 helper for counter widths.
- One sub-module, baud_tick_gen:
  - Parameter DIV.
  - Inputs CLK50M, RST, clr; output tick.
  - Shared later with the transmitter.

Test Plan:
- Bench parameters: CLK_FREQ=3200000, BAUD=100000, OVERSAMPLE=16, so DIV=2 and one bit = 32 cycles.
- Frame 0x61 (start, 1,0,0,0,0,1,1,0, stop) → rx_data=0x61; a single rx_valid pulse ~307 cycles after the start edge; rx_frame_err stays 0.
- RX low for 8 cycles then high → no rx_valid or rx_frame_err; rx_busy returns to 0 within 20 cycles.
- 0x55 with stop bit driven 0 → rx_frame_err pulses once; rx_data keeps its prior value 0x61. With RX held low, rx_busy stays 1. After RX high for 32 cycles, a following 0xA3 frame → rx_valid with 0xA3.
- Back-to-back 0x00 then 0xFF (stop bit immediately followed by start) → two rx_valid pulses, data 0x00 then 0xFF, no errors.
- One-cycle RX glitch inverted at the mid-bit of data bit 3 in 0x0F → majority vote yields rx_data=0x0F.
- RST asserted at data bit 4 of 0x3C for 2 cycles → all outputs 0. Rest of the frame is ignored (no rx_valid while the line stays in that frame's bits). A fresh 0x3C frame afterwards → received correctly.
